// File: rtl/vs_omp_sequencer.sv
// OMP recovery-loop controller: sequences matrix load / inner products, batched max search and
// residual update, building the support set one atom per iteration until a stop condition.
module vs_omp_sequencer #(
  parameter int unsigned COLUMNS                    = 256,
  parameter int unsigned BATCH_SIZE                 = 64,
  parameter int unsigned K                          = 16,
  parameter logic [1:0]  CMD_COMPUTE_INNER_PRODUCTS = 2'd0,
  parameter logic [1:0]  CMD_LOAD_SENSING_MATRIX    = 2'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        load_matrix,
  input  logic [31:0] threshold,
  output logic        done,
  output logic        busy,
  output logic [1:0]  stop_reason,
  output logic [7:0]  support_count,
  input  logic [7:0]  support_rd_addr,
  output logic [7:0]  support_rd_data,
  output logic [1:0]  smp_command,
  output logic        smp_start,
  input  logic        smp_done,
  output logic        mid_clear,
  output logic        mid_start,
  input  logic        mid_batch_done,
  input  logic [7:0]  mid_location,
  input  logic [31:0] mid_max_value,
  output logic        upd_start,
  output logic [7:0]  upd_atom,
  input  logic        upd_done
);

  localparam int unsigned MaxBatches = COLUMNS / BATCH_SIZE;
  localparam int unsigned BatchW     = (MaxBatches > 1) ? $clog2(MaxBatches) : 1;
  localparam logic [BatchW-1:0] LastBatch = BatchW'(MaxBatches - 1);
  localparam logic [7:0] KCount = 8'(K);

  typedef enum logic [3:0] {
    StIdle, StLoadStart, StLoadWait, StIpStart, StIpWait, StMaxStart, StMaxWait,
    StSelect, StUpdStart, StUpdWait, StFinish
  } state_e;

  state_e            state_q;
  logic [BatchW-1:0] batch_q;
  logic [7:0]        support_q [K];

  logic [31:0] abs_max;
  logic        below_thr;
  logic        is_dup;
  logic        accept;

  // Saturating abs so the most negative value still compares as a large magnitude.
  always_comb begin
    abs_max = mid_max_value;
    if (mid_max_value == 32'h8000_0000) begin
      abs_max = 32'h7FFF_FFFF;
    end else if (mid_max_value[31]) begin
      abs_max = ~mid_max_value + 32'd1;
    end
  end

  assign below_thr = (abs_max <= threshold);

  always_comb begin
    is_dup = 1'b0;
    for (int unsigned i = 0; i < K; i++) begin
      if ((8'(i) < support_count) && (support_q[i] == mid_location)) begin
        is_dup = 1'b1;
      end
    end
  end

  // Entries at or above support_count are stale from earlier runs and read back as zero.
  always_comb begin
    support_rd_data = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if ((support_rd_addr == 8'(i)) && (8'(i) < support_count)) begin
        support_rd_data = support_q[i];
      end
    end
  end

  assign accept = (state_q == StSelect) && !below_thr && !is_dup;

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (support_count == 8'(i)) begin
          support_q[i] <= mid_location;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      batch_q       <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      stop_reason   <= 2'd0;
      support_count <= 8'd0;
      smp_command   <= CMD_COMPUTE_INNER_PRODUCTS;
      smp_start     <= 1'b0;
      mid_clear     <= 1'b0;
      mid_start     <= 1'b0;
      upd_start     <= 1'b0;
      upd_atom      <= 8'd0;
    end else begin
      done      <= 1'b0;
      smp_start <= 1'b0;
      mid_clear <= 1'b0;
      mid_start <= 1'b0;
      upd_start <= 1'b0;
      // Pulses are registered on entry, so each is high exactly during its *Start state.
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy          <= 1'b1;
            support_count <= 8'd0;
            smp_start     <= 1'b1;
            if (load_matrix) begin
              state_q     <= StLoadStart;
              smp_command <= CMD_LOAD_SENSING_MATRIX;
            end else begin
              state_q     <= StIpStart;
              smp_command <= CMD_COMPUTE_INNER_PRODUCTS;
              mid_clear   <= 1'b1;
              batch_q     <= '0;
            end
          end
        end
        StLoadStart: state_q <= StLoadWait;
        StLoadWait: begin
          if (smp_done) begin
            state_q     <= StIpStart;
            smp_command <= CMD_COMPUTE_INNER_PRODUCTS;
            smp_start   <= 1'b1;
            mid_clear   <= 1'b1;
            batch_q     <= '0;
          end
        end
        StIpStart: state_q <= StIpWait;
        StIpWait: begin
          if (smp_done) begin
            state_q   <= StMaxStart;
            mid_start <= 1'b1;
          end
        end
        StMaxStart: state_q <= StMaxWait;
        StMaxWait: begin
          if (mid_batch_done) begin
            if (batch_q == LastBatch) begin
              state_q <= StSelect;
            end else begin
              batch_q   <= batch_q + 1'b1;
              state_q   <= StMaxStart;
              mid_start <= 1'b1;
            end
          end
        end
        StSelect: begin
          if (below_thr) begin
            stop_reason <= 2'd1;
            state_q     <= StFinish;
            done        <= 1'b1;
          end else if (is_dup) begin
            stop_reason <= 2'd2;
            state_q     <= StFinish;
            done        <= 1'b1;
          end else begin
            support_count <= support_count + 8'd1;
            upd_atom      <= mid_location;
            upd_start     <= 1'b1;
            state_q       <= StUpdStart;
          end
        end
        StUpdStart: state_q <= StUpdWait;
        StUpdWait: begin
          if (upd_done) begin
            if (support_count == KCount) begin
              stop_reason <= 2'd0;
              state_q     <= StFinish;
              done        <= 1'b1;
            end else begin
              state_q     <= StIpStart;
              smp_command <= CMD_COMPUTE_INNER_PRODUCTS;
              smp_start   <= 1'b1;
              mid_clear   <= 1'b1;
              batch_q     <= '0;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
